// File: rtl/accumulator32.sv
// Packet accumulator: sums 32-bit beats through an adder32-equivalent path and returns the total
// on a valid/ready result port. Optional macro ACCUM_SATURATE_EN clamps the sum at all-ones on carry.
module accumulator32 #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [31:0]        out_sum,
  output logic               out_carry,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int DATA_W = 32;

  typedef enum logic {S_ACCUM, S_DONE} state_t;

  state_t state;

  // adder32 with cin tied low: {cout, s}
  function automatic logic [DATA_W:0] add33(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [DATA_W-1:0] sat_sum(input logic [DATA_W-1:0] s,
                                                input logic cout);
`ifdef ACCUM_SATURATE_EN
    return cout ? {DATA_W{1'b1}} : s;
`else
    return s;
`endif
  endfunction

  logic [DATA_W:0]   add_p0;
  logic [DATA_W-1:0] sum_p0;
  logic              cout_p0;
  logic              accept_p0;

  always_comb begin
    add_p0    = add33(out_sum, in_data);
    cout_p0   = add_p0[DATA_W];
    sum_p0    = sat_sum(add_p0[DATA_W-1:0], cout_p0);
    accept_p0 = in_valid & in_ready;
  end

  // Registered result stage; reset discards any partial packet
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_ACCUM;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_count <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        S_ACCUM: begin
          if (accept_p0) begin
            out_sum   <= sum_p0;
            out_carry <= out_carry | cout_p0;
            out_count <= out_count + COUNT_W'(1);
            if (in_last) begin
              state     <= S_DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_valid && out_ready) begin
            state     <= S_ACCUM;
            out_sum   <= '0;
            out_carry <= 1'b0;
            out_count <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_ACCUM;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
